ifetch_queue: RTL and testbench

//  Instruction-fetch front end that sits upstream of the IF/ID register. Fetches

---
 rtl/ifetch_queue.sv | 144 ++++++++++++++
 tb/tb_ifetch_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch over a req/ack memory handshake,
// buffered in a small FIFO of {inst, pc+4} pairs, with redirect flush and stale-request drop.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc4,
    input  logic                     out_hold,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [31:0]   fetch_pc_r, fetch_pc_s;
    logic [31:0]   drop_pc_r, drop_pc_s;
    logic [AW:0]   count_r, count_s;
    logic [AW-1:0] rd_ptr_r, wr_ptr_r;
    logic [63:0]   mem_r [DEPTH];
    logic          push_s, pop_s;
    logic [31:0]   redir_pc_s;

    assign redir_pc_s = {redirect_pc[31:2], 2'b00};
    assign out_valid  = (count_r != {(AW+1){1'b0}});
    assign pop_s      = out_valid & ~out_hold & ~redirect;
    assign push_s     = (state_r == REQ) & imem_ack & ~redirect;

    assign imem_req  = (state_r != IDLE);
    assign imem_addr = (state_r == DROP) ? drop_pc_r : fetch_pc_r;
    assign out_inst  = out_valid ? mem_r[rd_ptr_r][63:32] : 32'h0;
    assign out_pc4   = out_valid ? mem_r[rd_ptr_r][31:0]  : 32'h0;
    assign count     = count_r;

    // Occupancy update; a redirect empties the queue regardless of push/pop.
    always_comb begin
        count_s = count_r;
        if (redirect) begin
            count_s = {(AW+1){1'b0}};
        end else begin
            count_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        end
    end

    // Fetch FSM next state and fetch/drop address bookkeeping.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        drop_pc_s  = drop_pc_r;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_s = redir_pc_s;
                    state_s    = REQ;
                end else if (count_r < FULL) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect && imem_ack) begin
                    fetch_pc_s = redir_pc_s;
                    state_s    = REQ;
                end else if (redirect) begin
                    // Memory still owes us a word for the old address; keep asking for it.
                    drop_pc_s  = fetch_pc_r;
                    fetch_pc_s = redir_pc_s;
                    state_s    = DROP;
                end else if (imem_ack) begin
                    fetch_pc_s = fetch_pc_r + 32'd4;
                    state_s    = (count_s < FULL) ? REQ : IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_s = redir_pc_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (imem_ack) begin
                    state_s = REQ;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, pointers and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            drop_pc_r  <= RESET_PC;
            count_r    <= {(AW+1){1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            drop_pc_r  <= drop_pc_s;
            count_r    <= count_s;
            if (redirect) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
            end else begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, push_s};
            end
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {imem_data, fetch_pc_r + 32'd4};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios followed by random traffic, all checked
// each cycle against a transaction-level model (a queue plus an outstanding-request flag).
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc4;
    logic        out_hold;
    logic [2:0]  count;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_saddr;
    bit          m_req;
    bit          m_stale;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc4(out_pc4), .out_hold(out_hold), .count(count)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_data = memf(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic compare_outputs();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk("imem_req",  {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) chk("imem_addr", imem_addr, m_stale ? m_saddr : m_pc);
        else       chk("idle_addr", imem_addr, m_pc);
        chk("count",     {29'd0, count}, 32'(mq.size()));
        chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
        chk("out_inst",  out_inst, head[63:32]);
        chk("out_pc4",   out_pc4,  head[31:0]);
    endtask

    task automatic model_update(input bit r, input bit rd, input logic [31:0] rpc,
                                input bit a, input bit h);
        bit pop;
        if (r) begin
            mq.delete();
            m_pc = RESET_PC; m_saddr = RESET_PC; m_req = 1'b0; m_stale = 1'b0;
        end else begin
            pop = (mq.size() != 0) && !h && !rd;
            if (rd) begin
                if (m_req && !m_stale && !a) begin
                    m_stale = 1'b1; m_saddr = m_pc;
                end else if (m_req && m_stale && a) begin
                    m_stale = 1'b0;
                end
                mq.delete();
                m_pc  = {rpc[31:2], 2'b00};
                m_req = 1'b1;
            end else if (m_req && m_stale) begin
                if (a) m_stale = 1'b0;
                if (pop) void'(mq.pop_front());
            end else if (m_req) begin
                if (pop) void'(mq.pop_front());
                if (a) begin
                    mq.push_back({memf(m_pc), m_pc + 32'd4});
                    m_pc  = m_pc + 32'd4;
                    m_req = (mq.size() < DEPTH);
                end
            end else begin
                m_req = (mq.size() < DEPTH);
                if (pop) void'(mq.pop_front());
            end
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit a, input bit h);
        rst = r; redirect = rd; redirect_pc = rpc; imem_ack = a; out_hold = h;
        #3;
        if (chk_en) compare_outputs();
        @(posedge clk);
        model_update(r, rd, rpc, a, h);
        chk_en = 1'b1;
        #1;
    endtask

    initial begin
        bit reached;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; imem_ack = 1'b0; out_hold = 1'b0;

        // reset, then streaming with ack tied high
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_pc4", out_pc4, 32'd44);

        // hold for 10 cycles: queue saturates, then drains
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("full_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // delayed ack: one ack every 4th cycle
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 32'd0, (i % 4) == 3, 1'b0);

        // redirect to 0x40 while waiting on 0x10
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (imem_req && imem_addr == 32'h10) reached = 1'b1;
            else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("reach_0x10", {31'd0, reached}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // redirect coincident with ack and pop at count 3
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (count == 3'd3 && imem_req) reached = 1'b1;
            else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        end
        chk("reach_cnt3", {31'd0, reached}, 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
        chk("flush_count", {29'd0, count}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // reset while dropping a stale request
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // random traffic, including redirects near the top of the address space
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
